// File: rtl/cache_pkg.sv
// cache_pkg: shared cache geometry defaults and refill FSM state encoding.
package cache_pkg;
    localparam int DEF_TAG_BITS        = 18;
    localparam int DEF_INDEX_BITS      = 8;
    localparam int DEF_OFFSET_BITS     = 6;
    localparam int DEF_LINE_SIZE_BYTES = 64;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_ADDRESS_WIDTH   = 32;
    localparam int DEF_WAYS            = 4;
    localparam int DEF_BEATS           = DEF_LINE_SIZE_BYTES * 8 / DEF_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SELECT    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_FILL      = 3'd3,
        S_UPDATE    = 3'd4
    } state_e;
endpackage

// File: rtl/victim_select.sv
// victim_select: combinational replacement choice for one set.
//   i_valid : valid bit per way
//   i_lru   : LRU bit per way (0 = candidate for replacement)
//   o_way   : lowest invalid way, else lowest way with LRU 0, else way 0
module victim_select #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-1:0]         i_valid,
    input  logic [WAYS-1:0]         i_lru,
    output logic [$clog2(WAYS)-1:0] o_way
);
    logic found_inv;
    logic found_lru;
    logic [$clog2(WAYS)-1:0] inv_way;
    logic [$clog2(WAYS)-1:0] lru_way;

    always_comb begin
        found_inv = 1'b0;
        found_lru = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_inv && !i_valid[w]) begin
                found_inv = 1'b1;
                inv_way   = $clog2(WAYS)'(w);
            end
            if (!found_lru && !i_lru[w]) begin
                found_lru = 1'b1;
                lru_way   = $clog2(WAYS)'(w);
            end
        end
        o_way = found_inv ? inv_way : found_lru ? lru_way : '0;
    end
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler that selects a victim, writes it back if
// dirty, refills the line beat by beat and writes it into the cache array.
//   clk, rst (async active-low)
//   i_miss_valid/o_miss_ready, i_tag, i_index    : miss handshake
//   i_way_valid/dirty/lru/tag, i_victim_data      : set state from lookup
//   o_victim_way                                  : registered victim way
//   o_mem_valid/i_mem_ready, o_mem_we, o_mem_addr,
//   o_mem_wdata, i_mem_rdata                      : beat memory port
//   o_line_we, o_line_index/way/tag/data,
//   o_line_valid/dirty                            : array write
//   o_busy, o_done                                : status
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int TAG_BITS        = DEF_TAG_BITS,
    parameter int INDEX_BITS      = DEF_INDEX_BITS,
    parameter int OFFSET_BITS     = DEF_OFFSET_BITS,
    parameter int LINE_SIZE_BYTES = DEF_LINE_SIZE_BYTES,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
    parameter int WAYS            = DEF_WAYS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_miss_valid,
    output logic                         o_miss_ready,
    input  logic [TAG_BITS-1:0]          i_tag,
    input  logic [INDEX_BITS-1:0]        i_index,
    input  logic [WAYS-1:0]              i_way_valid,
    input  logic [WAYS-1:0]              i_way_dirty,
    input  logic [WAYS-1:0]              i_way_lru,
    input  logic [WAYS*TAG_BITS-1:0]     i_way_tag,
    input  logic [LINE_SIZE_BYTES*8-1:0] i_victim_data,
    output logic [$clog2(WAYS)-1:0]      o_victim_way,
    output logic                         o_mem_valid,
    input  logic                         i_mem_ready,
    output logic                         o_mem_we,
    output logic [ADDRESS_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]        o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]        i_mem_rdata,
    output logic                         o_line_we,
    output logic [INDEX_BITS-1:0]        o_line_index,
    output logic [$clog2(WAYS)-1:0]      o_line_way,
    output logic [TAG_BITS-1:0]          o_line_tag,
    output logic [LINE_SIZE_BYTES*8-1:0] o_line_data,
    output logic                         o_line_valid,
    output logic                         o_line_dirty,
    output logic                         o_busy,
    output logic                         o_done
);
    localparam int BEATS     = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
    localparam int BEAT_BITS = $clog2(BEATS);
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int LINE_BITS = LINE_SIZE_BYTES * 8;
    localparam int LOW_BITS  = OFFSET_BITS - BEAT_BITS;

    state_e                state_q, state_d;
    logic [BEAT_BITS-1:0]  beat_q, beat_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [TAG_BITS-1:0]   vtag_q, vtag_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    logic [WAY_BITS-1:0]   way_q, way_d;
    logic [LINE_BITS-1:0]  line_q, line_d;
    logic [WAY_BITS-1:0]   sel_way;
    logic                  sel_dirty;
    logic                  last_beat;
    logic                  beat_fire;

    victim_select #(.WAYS(WAYS)) u_victim_select (
        .i_valid(i_way_valid),
        .i_lru  (i_way_lru),
        .o_way  (sel_way)
    );

    assign sel_dirty = i_way_valid[sel_way] & i_way_dirty[sel_way];
    assign last_beat = beat_q == BEAT_BITS'(BEATS - 1);
    assign beat_fire = o_mem_valid & i_mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q  <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            index_q <= '0;
            way_q   <= '0;
            line_q  <= '0;
        end else begin
            beat_q  <= beat_d;
            tag_q   <= tag_d;
            vtag_q  <= vtag_d;
            index_q <= index_d;
            way_q   <= way_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = i_miss_valid ? S_SELECT : S_IDLE;
            S_SELECT:    state_d = sel_dirty ? S_WRITEBACK : S_FILL;
            S_WRITEBACK: state_d = (beat_fire && last_beat) ? S_FILL : S_WRITEBACK;
            S_FILL:      state_d = (beat_fire && last_beat) ? S_UPDATE : S_FILL;
            S_UPDATE:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // One line buffer serves both directions: it holds the victim during
    // writeback and is overwritten beat by beat during the fill.
    always_comb begin
        tag_d   = tag_q;
        vtag_d  = vtag_q;
        index_d = index_q;
        way_d   = way_q;
        line_d  = line_q;
        beat_d  = beat_fire ? (last_beat ? '0 : beat_q + 1'b1) : beat_q;
        if (o_miss_ready && i_miss_valid) begin
            tag_d   = i_tag;
            index_d = i_index;
        end
        if (state_q == S_SELECT) begin
            way_d  = sel_way;
            vtag_d = i_way_tag[sel_way*TAG_BITS +: TAG_BITS];
            line_d = i_victim_data;
            beat_d = '0;
        end
        if (state_q == S_FILL && beat_fire) begin
            line_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = i_mem_rdata;
        end
    end

    // Outputs are gated to zero outside their active states so the idle and
    // reset values are all-zero apart from o_miss_ready.
    always_comb begin
        o_miss_ready = state_q == S_IDLE;
        o_busy       = state_q != S_IDLE;
        o_mem_valid  = (state_q == S_WRITEBACK) || (state_q == S_FILL);
        o_mem_we     = state_q == S_WRITEBACK;
        o_mem_addr   = o_mem_valid ? ADDRESS_WIDTH'({o_mem_we ? vtag_q : tag_q, index_q, beat_q, {LOW_BITS{1'b0}}}) : '0;
        o_mem_wdata  = o_mem_we ? line_q[beat_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        o_line_we    = state_q == S_UPDATE;
        o_done       = o_line_we;
        o_line_index = o_line_we ? index_q : '0;
        o_line_way   = o_line_we ? way_q : '0;
        o_line_tag   = o_line_we ? tag_q : '0;
        o_line_data  = o_line_we ? line_q : '0;
        o_line_valid = o_line_we;
        o_line_dirty = 1'b0;
    end

    assign o_victim_way = way_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed tests with a per-cycle reference model of the refill sequence.
module tb_cache_refill_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_miss_valid = 1'b0;
    logic         o_miss_ready;
    logic [17:0]  i_tag = '0;
    logic [7:0]   i_index = '0;
    logic [3:0]   i_way_valid = '0;
    logic [3:0]   i_way_dirty = '0;
    logic [3:0]   i_way_lru = '0;
    logic [71:0]  i_way_tag = '0;
    logic [511:0] i_victim_data = '0;
    logic [1:0]   o_victim_way;
    logic         o_mem_valid;
    logic         i_mem_ready = 1'b1;
    logic         o_mem_we;
    logic [31:0]  o_mem_addr;
    logic [31:0]  o_mem_wdata;
    logic [31:0]  i_mem_rdata = '0;
    logic         o_line_we;
    logic [7:0]   o_line_index;
    logic [1:0]   o_line_way;
    logic [17:0]  o_line_tag;
    logic [511:0] o_line_data;
    logic         o_line_valid;
    logic         o_line_dirty;
    logic         o_busy;
    logic         o_done;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .i_miss_valid(i_miss_valid), .o_miss_ready(o_miss_ready),
        .i_tag(i_tag), .i_index(i_index),
        .i_way_valid(i_way_valid), .i_way_dirty(i_way_dirty), .i_way_lru(i_way_lru),
        .i_way_tag(i_way_tag), .i_victim_data(i_victim_data),
        .o_victim_way(o_victim_way),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_line_we(o_line_we), .o_line_index(o_line_index), .o_line_way(o_line_way),
        .o_line_tag(o_line_tag), .o_line_data(o_line_data),
        .o_line_valid(o_line_valid), .o_line_dirty(o_line_dirty),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    beat_t        exp_q[$];
    logic [511:0] exp_line;
    logic [1:0]   exp_way;
    logic [17:0]  exp_tag;
    logic [7:0]   exp_idx;
    bit           exp_pending = 0;
    int           exp_latency = 0;

    int accept_cnt = 0, accept_cyc = 0;
    int line_we_cnt = 0, done_cyc = 0, last_latency = 0;
    bit stall_en = 0;
    int stall_left[2];
    bit prev_stall = 0;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;
    int          acc_n = 0;
    logic [31:0] acc_addr[64];
    logic        acc_we[64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic int pick_victim(input logic [3:0] v, input logic [3:0] lru);
        for (int w = 0; w < 4; w++) if (!v[w]) return w;
        for (int w = 0; w < 4; w++) if (!lru[w]) return w;
        return 0;
    endfunction

    // Build the whole expected transaction from the set state at acceptance.
    function automatic void model_accept();
        int w;
        logic [17:0] vt;
        logic [31:0] a;
        w  = pick_victim(i_way_valid, i_way_lru);
        vt = i_way_tag[w*18 +: 18];
        exp_q.delete();
        if (i_way_valid[w] && i_way_dirty[w])
            for (int k = 0; k < 16; k++) begin
                a = (32'(vt) << 14) + (32'(i_index) << 6) + (32'(k) << 2);
                exp_q.push_back('{1'b1, a, i_victim_data[k*32 +: 32]});
            end
        for (int k = 0; k < 16; k++) begin
            a = (32'(i_tag) << 14) + (32'(i_index) << 6) + (32'(k) << 2);
            exp_q.push_back('{1'b0, a, 32'h0});
            exp_line[k*32 +: 32] = mem_word(a);
        end
        exp_way     = 2'(w);
        exp_tag     = i_tag;
        exp_idx     = i_index;
        exp_pending = 1;
        exp_latency = 2 + exp_q.size();
        accept_cyc  = cyc;
        accept_cnt++;
        acc_n = 0;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_mem_valid", o_mem_valid, 0);
            chk("rst_miss_ready", o_miss_ready, 1);
            chk("rst_line_we", o_line_we, 0);
            chk("rst_busy", o_busy, 0);
            i_mem_ready = 1'b1;
        end else begin
            chk("busy_vs_ready", o_busy, !o_miss_ready);
            chk("done_vs_line_we", o_done, o_line_we);
            if (o_miss_ready && i_miss_valid) model_accept();
            if (prev_stall) begin
                chk("stall_valid", o_mem_valid, 1);
                chk("stall_addr", o_mem_addr, prev_addr);
                chk("stall_we", o_mem_we, prev_we);
                chk("stall_wdata", o_mem_wdata, prev_wdata);
            end
            prev_stall  = 0;
            i_mem_ready = 1'b1;
            if (o_mem_valid) begin
                chk("victim_way_busy", o_victim_way, exp_way);
                chk("beats_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("beat_we", o_mem_we, exp_q[0].we);
                    chk("beat_addr", o_mem_addr, exp_q[0].addr);
                    if (exp_q[0].we) chk("beat_wdata", o_mem_wdata, exp_q[0].data);
                end
                if (stall_en && o_mem_addr[5:2] == 4'd7 && stall_left[o_mem_we] > 0) begin
                    i_mem_ready = 1'b0;
                    stall_left[o_mem_we]--;
                    exp_latency++;
                    prev_stall = 1;
                    prev_addr  = o_mem_addr;
                    prev_we    = o_mem_we;
                    prev_wdata = o_mem_wdata;
                end else begin
                    if (acc_n < 64) begin
                        acc_addr[acc_n] = o_mem_addr;
                        acc_we[acc_n]   = o_mem_we;
                        acc_n++;
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                i_mem_rdata = mem_word(o_mem_addr);
            end
            if (o_line_we) begin
                chk("line_expected", exp_pending, 1);
                chk("line_beats_left", exp_q.size(), 0);
                chk("line_index", o_line_index, exp_idx);
                chk("line_way", o_line_way, exp_way);
                chk("line_tag", o_line_tag, exp_tag);
                chk("line_data", o_line_data, exp_line);
                chk("line_valid", o_line_valid, 1);
                chk("line_dirty", o_line_dirty, 0);
                chk("latency", cyc - accept_cyc, exp_latency);
                last_latency = cyc - accept_cyc;
                done_cyc     = cyc;
                exp_pending  = 0;
                line_we_cnt++;
            end
        end
    end

    task automatic wait_accept(input int prev);
        int n = 0;
        while (accept_cnt == prev && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", accept_cnt != prev, 1);
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (line_we_cnt == prev && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", line_we_cnt != prev, 1);
    endtask

    task automatic setup(input logic [17:0] tag, input logic [7:0] idx, input logic [3:0] v,
                         input logic [3:0] lru, input logic [3:0] d, input logic [71:0] tags);
        i_tag = tag;
        i_index = idx;
        i_way_valid = v;
        i_way_lru = lru;
        i_way_dirty = d;
        i_way_tag = tags;
        for (int k = 0; k < 16; k++) i_victim_data[k*32 +: 32] = 32'hC0DE0000 + (32'(idx) << 8) + 32'(k);
    endtask

    task automatic run_miss();
        int pa, pd;
        pa = accept_cnt;
        pd = line_we_cnt;
        i_miss_valid = 1'b1;
        wait_accept(pa);
        i_miss_valid = 1'b0;
        wait_done(pd);
    endtask

    initial begin
        int n, pa, pd, d1, we_before;
        #2;
        chk("reset_miss_ready", o_miss_ready, 1);
        chk("reset_mem_valid", o_mem_valid, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_mem_addr", o_mem_addr, 0);
        chk("reset_victim_way", o_victim_way, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // clean miss, LRU picks way 2
        setup(18'h12345, 8'h3C, 4'b1111, 4'b1011, 4'b0000, {18'h4, 18'h3, 18'h2, 18'h1});
        run_miss();
        chk("clean_way", o_victim_way, 2);
        chk("clean_latency", last_latency, 18);
        chk("clean_reads", acc_n, 16);

        // dirty victim way 0 with stored tag 0x2A0
        setup(18'h0002A, 8'h05, 4'b1111, 4'b1110, 4'b0001, {18'h3, 18'h2, 18'h1, 18'h2A0});
        run_miss();
        chk("dirty_way", o_victim_way, 0);
        chk("dirty_latency", last_latency, 34);
        chk("dirty_beats", acc_n, 32);
        chk("dirty_first_addr", acc_addr[0], 32'h00A80140);
        chk("dirty_last_wr_addr", acc_addr[15], 32'h00A8017C);
        chk("dirty_last_wr_we", acc_we[15], 1);
        chk("dirty_first_rd_we", acc_we[16], 0);
        chk("dirty_first_rd_addr", acc_addr[16], 32'h000A8140);

        // invalid way 2 wins regardless of LRU/dirty
        setup(18'h00777, 8'hA1, 4'b1011, 4'b0000, 4'b1111, {18'h9, 18'h8, 18'h7, 18'h6});
        run_miss();
        chk("invalid_way", o_victim_way, 2);
        chk("invalid_latency", last_latency, 18);
        chk("invalid_no_wb", acc_we[0], 0);

        // back-pressure on beat 7 of both writeback and fill
        setup(18'h15555, 8'h7E, 4'b1111, 4'b0111, 4'b1000, {18'h3AAAA, 18'h2, 18'h1, 18'h0});
        stall_en = 1;
        stall_left[0] = 3;
        stall_left[1] = 3;
        run_miss();
        stall_en = 0;
        chk("stall_way", o_victim_way, 3);
        chk("stall_latency", last_latency, 40);
        chk("stall_beats", acc_n, 32);
        chk("stall_wb_beat8", acc_addr[8][5:2], 8);
        chk("stall_rd_beat7", acc_addr[23][5:2], 7);

        // reset during fill beat 9
        setup(18'h00BEE, 8'h11, 4'b1111, 4'b1101, 4'b0000, {18'h0, 18'h0, 18'h0, 18'h0});
        pa = accept_cnt;
        i_miss_valid = 1'b1;
        wait_accept(pa);
        i_miss_valid = 1'b0;
        n = 0;
        while (!(o_mem_valid && !o_mem_we && o_mem_addr[5:2] == 4'd9) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_fill_beat9", o_mem_valid && !o_mem_we && o_mem_addr[5:2] == 4'd9, 1);
        we_before = line_we_cnt;
        rst = 1'b0;
        exp_q.delete();
        exp_pending = 0;
        prev_stall = 0;
        #1;
        chk("abort_mem_valid", o_mem_valid, 0);
        chk("abort_miss_ready", o_miss_ready, 1);
        chk("abort_busy", o_busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("release_miss_ready", o_miss_ready, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_line_we", line_we_cnt, we_before);
        chk("abort_idle", o_busy, 0);

        // miss held through UPDATE is taken the cycle after o_done
        setup(18'h0CAFE, 8'h42, 4'b1111, 4'b1111, 4'b0000, {18'h0, 18'h0, 18'h0, 18'h0});
        pa = accept_cnt;
        pd = line_we_cnt;
        i_miss_valid = 1'b1;
        wait_accept(pa);
        wait_done(pd);
        d1 = done_cyc;
        wait_accept(pa + 1);
        chk("reaccept_gap", accept_cyc - d1, 1);
        i_miss_valid = 1'b0;
        wait_done(pd + 1);
        chk("held_way", o_victim_way, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("held_idle", o_busy, 0);
        chk("held_accepts", accept_cnt, pa + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameters: TAG_BITS 18, tag width; INDEX_BITS 8, set index width; OFFSET_BITS 6, byte offset width; LINE_SIZE_BYTES 64, line size; DATA_WIDTH 32, memory beat width; ADDRESS_WIDTH 32, memory address width; WAYS 4, associativity.
REQ-002 SHALL derive BEATS = LINE_SIZE_BYTES*8/DATA_WIDTH (16 at defaults).
REQ-003 SHALL have ports (name, direction, width, meaning):
  clk  in  1  single clock, rising edge;
  rst  in  1  asynchronous, active-low reset;
  i_miss_valid  in  1  lookup reports a miss;
  o_miss_ready  out  1  miss accepted when high with i_miss_valid;
  i_tag  in  TAG_BITS  missing tag;
  i_index  in  INDEX_BITS  missing set;
  i_way_valid  in  WAYS  valid bit per way of set i_index;
  i_way_dirty  in  WAYS  dirty bit per way;
  i_way_lru  in  WAYS  LRU bit per way;
  i_way_tag  in  WAYS*TAG_BITS  stored tags, way 0 in LSBs;
  i_victim_data  in  LINE_SIZE_BYTES*8  line data of selected way;
  o_victim_way  out  log2(WAYS)  registered victim way;
  o_mem_valid  out  1  memory beat request;
  i_mem_ready  in  1  beat accepted (read data valid same cycle);
  o_mem_we  out  1  1 = write beat, 0 = read beat;
  o_mem_addr  out  ADDRESS_WIDTH  beat byte address;
  o_mem_wdata  out  DATA_WIDTH  write beat data;
  i_mem_rdata  in  DATA_WIDTH  read beat data;
  o_line_we  out  1  one-cycle array write strobe;
  o_line_index, o_line_way, o_line_tag  out  INDEX_BITS, log2(WAYS), TAG_BITS  array write target;
  o_line_data  out  LINE_SIZE_BYTES*8  refilled line;
  o_line_valid, o_line_dirty  out  1, 1  bits written with line;
  o_busy  out  1  not IDLE;
  o_done  out  1  one-cycle completion pulse.

Function
REQ-004 SHALL implement states IDLE, SELECT, WRITEBACK, FILL, UPDATE.
REQ-005 SHALL assert o_miss_ready only in IDLE; i_miss_valid & o_miss_ready registers i_tag/i_index and moves to SELECT.
REQ-006 SELECT (one cycle) SHALL pick victim: lowest-index invalid way; else lowest-index way with LRU bit 0; else way 0; register way, its tag, dirty flag.
REQ-007 SELECT SHALL go to WRITEBACK if victim valid and dirty, else FILL; i_victim_data SHALL be captured in SELECT.
REQ-008 Beat k address SHALL be {tag, index, k[log2(BEATS)-1:0], 2'b00}; beat k carries line bits [32k+31:32k]; beats issue in order 0..BEATS-1.
REQ-009 WRITEBACK SHALL use victim tag, o_mem_we=1, o_mem_wdata = captured beat k; FILL SHALL use miss tag, o_mem_we=0, store i_mem_rdata into beat k on acceptance.
REQ-010 Once o_mem_valid rises, addr/we/wdata SHALL hold stable until i_mem_ready; beat counter advances only on o_mem_valid & i_mem_ready.
REQ-011 After beat BEATS-1 accepted: WRITEBACK -> FILL (counter 0), FILL -> UPDATE; o_mem_valid SHALL be low in SELECT and UPDATE.
REQ-012 UPDATE (one cycle) SHALL pulse o_line_we and o_done with o_line_valid=1, o_line_dirty=0, miss tag/index, victim way, filled data; then IDLE.
REQ-013 Minimum latency, zero-wait memory, clean victim: accept cycle 0, UPDATE cycle 2+BEATS (18); dirty victim adds BEATS (34).
REQ-014 i_miss_valid during busy states SHALL be ignored, not queued; in UPDATE it is accepted next cycle in IDLE.

Reset
REQ-015 rst low SHALL immediately force IDLE, counter 0, all outputs 0 except o_miss_ready=1.
REQ-016 Reset mid-WRITEBACK/FILL SHALL drop o_mem_valid asynchronously, discard partial line, never pulse o_line_we.

Structure
REQ-017 Geometry defaults, BEATS and state encodings SHALL live in shared package cache_pkg.
REQ-018 Victim selection SHALL be sub-module victim_select (combinational: valid/lru in, way out).

Verification
REQ-019 Clean miss, i_way_valid=4'b1111, i_way_lru=4'b1011, dirty=0, ready tied 1 -> victim way 2, 16 reads, o_line_we at cycle 18.
REQ-020 Dirty victim, tag 0x2A, index 0x05 -> 16 writes addr 0x00A80140..0x00A8017C, then 16 reads, done cycle 34.
REQ-021 i_way_valid=4'b1011 -> victim way 2 regardless of LRU/dirty; no writeback.
REQ-022 i_mem_ready low 3 cycles on beat 7 -> addr/wdata stable, beat 7 issued once, line data matches memory model.
REQ-023 rst low at FILL beat 9 -> o_mem_valid 0 same cycle, o_line_we never asserts, o_miss_ready 1 after release.
REQ-024 i_miss_valid held during UPDATE -> second miss accepted exactly one cycle after o_done.
